bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter FIXED_PRIORITY, default 0, SHALL select the policy: 0 = round-robin, 1 = port A always wins.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 a_address  input  16  SHALL carry the port A (instruction fetch) byte address.
REQ-005 a_data_tx  input  8  SHALL carry the port A write data.
REQ-006 a_read, a_write  input  1 each  SHALL carry the port A request strobes.
REQ-007 a_data_rx  output  8  SHALL carry the port A read data.
REQ-008 a_wait  output  1  SHALL be the port A stall; low means the transaction is complete.
REQ-009 b_address, b_data_tx, b_read, b_write, b_data_rx, b_wait SHALL mirror the port A signals for port B (data access), with identical widths.
REQ-010 mem_address  output  16  SHALL carry the address to the memory controller.
REQ-011 mem_data_tx  output  8  SHALL carry the write data to the memory controller.
REQ-012 mem_read, mem_write  output  1 each  SHALL carry the request strobes to the memory controller.
REQ-013 mem_data_rx  input  8  SHALL carry the read data from the memory controller.
REQ-014 mem_wait  input  1  SHALL be the memory controller stall; it is high while busy or idle and low once data is valid.

Function
REQ-015 The state machine SHALL have exactly three states: IDLE, GRANT, RELEASE.
REQ-016 IDLE: a port is requesting when its read or write strobe is high.
REQ-017 IDLE: if any port is requesting, the block SHALL grant one port, register its address, write data and strobes, and enter GRANT on the next edge.
REQ-018 Latency: a request sampled in IDLE at edge N SHALL drive mem_read or mem_write high from edge N onward, i.e. valid in cycle N+1.
REQ-019 Round-robin (FIXED_PRIORITY=0): when both ports request, the block SHALL grant the port not granted last; the last-granted pointer resets to B, so A wins the first tie.
REQ-020 Fixed priority (FIXED_PRIORITY=1): when both ports request, the block SHALL grant port A.
REQ-021 A lone requester SHALL be granted regardless of policy.
REQ-022 If a port asserts both read and write, the block SHALL forward only mem_write.
REQ-023 GRANT: mem_address, mem_data_tx and the strobes SHALL come from the latched copies, held constant even if the requester changes or drops its inputs.
REQ-024 GRANT with mem_wait=0 at an edge: the block SHALL capture mem_data_rx into the granted port's data_rx register.
REQ-025 On that same edge the block SHALL drive the granted port's wait low for exactly one cycle and clear mem_read and mem_write.
REQ-026 On that same edge the block SHALL update the last-granted pointer and enter RELEASE.
REQ-027 A request abandoned mid-GRANT SHALL still run to completion, including the one-cycle wait-low pulse.
REQ-028 RELEASE: requests SHALL be ignored and the strobes held low until mem_wait=1 is sampled, then the block SHALL enter IDLE.
REQ-029 The RELEASE rule SHALL give the controller's dummy-clock/deselect phase time to finish before the next access.
REQ-030 A non-granted port's wait SHALL stay high throughout; its data_rx SHALL hold its last value.
REQ-031 Each port's wait SHALL be high in every cycle except its single completion cycle.
REQ-032 mem_address and mem_data_tx SHALL be 0 in IDLE and RELEASE.
REQ-033 Starvation bound (round-robin): with both ports continuously requesting, no port SHALL wait more than one foreign transaction.

Reset
REQ-034 On rst_n low, the block SHALL immediately and asynchronously enter IDLE, independent of clk.
REQ-035 Reset values: mem_read=0, mem_write=0, a_wait=1, b_wait=1, a_data_rx=0, b_data_rx=0, last-granted=B, latches=0.
REQ-036 Reset asserted mid-GRANT SHALL drop the memory strobes within the same cycle and generate no completion pulse.
REQ-037 After rst_n deasserts, the block SHALL sample requests from the first rising edge.

Verification
REQ-038 A reads 0x0123 alone; memory model returns 0x5A after 6 cycles -> mem_read high 1 cycle after request; a_data_rx=0x5A; a_wait low exactly 1 cycle; b_wait always 1.
REQ-039 A and B request reads in the same cycle, FIXED_PRIORITY=0 -> A served first, B second; neither strobe active while mem_wait=0 persists after completion.
REQ-040 Both ports request continuously for 6 transactions -> grant order A,B,A,B,A,B; FIXED_PRIORITY=1 -> A,A,A,... with B starved.
REQ-041 B writes 0xC3 to 0x8010, then drops b_write and changes b_address to 0x0000 mid-GRANT -> mem_address stays 0x8010, mem_data_tx stays 0xC3, mem_write held until mem_wait=0.
REQ-042 rst_n pulsed low between clock edges during GRANT -> mem_read=0 before the next edge; a_wait=b_wait=1; next access starts from IDLE with A winning a tie.
REQ-043 Memory model holds mem_wait=0 for 3 cycles after completion (dummy clock) -> no new strobe until mem_wait returns to 1; no second wait pulse.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// One bus port: request side (address, write data, strobes) and response side
// (read data, stall). Used for both requesting ports and for the memory side.
interface bus_arbiter_if;
    logic [15:0] address;
    logic [7:0]  data_tx;
    logic        read;
    logic        write;
    logic [7:0]  data_rx;
    logic        stall;     // the "wait" line: high until the transaction completes

    modport master (
        output address, data_tx, read, write,
        input  data_rx, stall
    );

    modport slave (
        input  address, data_tx, read, write,
        output data_rx, stall
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-port arbiter in front of a single memory controller: port A (fetch) and
// port B (data) share one bus, round-robin or A-first, one access at a time.
module bus_arbiter #(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    bus_arbiter_if.slave   a_bus,
    bus_arbiter_if.slave   b_bus,
    bus_arbiter_if.master  mem_bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    state_t      r_state;
    port_t       r_last;
    port_t       r_owner;
    logic [15:0] r_address;
    logic [7:0]  r_data_tx;
    logic        r_read;
    logic        r_write;
    logic [7:0]  r_a_data_rx;
    logic [7:0]  r_b_data_rx;
    logic        r_a_wait;
    logic        r_b_wait;

    logic        w_a_req;
    logic        w_b_req;
    port_t       w_pick;
    logic [15:0] w_address;
    logic [7:0]  w_data_tx;
    logic        w_read;
    logic        w_write;

    assign w_a_req = a_bus.read | a_bus.write;
    assign w_b_req = b_bus.read | b_bus.write;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_pick    = PORT_A;
        w_address = 16'h0000;
        w_data_tx = 8'h00;
        w_read    = 1'b0;
        w_write   = 1'b0;

        if (w_a_req && w_b_req) begin
            w_pick = (FIXED_PRIORITY || (r_last == PORT_B)) ? PORT_A : PORT_B;
        end else if (w_b_req) begin
            w_pick = PORT_B;
        end

        // A write wins over a simultaneous read on the same port.
        if (w_pick == PORT_B) begin
            w_address = b_bus.address;
            w_data_tx = b_bus.data_tx;
            w_write   = b_bus.write;
            w_read    = b_bus.read & ~b_bus.write;
        end else begin
            w_address = a_bus.address;
            w_data_tx = a_bus.data_tx;
            w_write   = a_bus.write;
            w_read    = a_bus.read & ~a_bus.write;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_last      <= PORT_B;
            r_owner     <= PORT_A;
            r_address   <= 16'h0000;
            r_data_tx   <= 8'h00;
            r_read      <= 1'b0;
            r_write     <= 1'b0;
            r_a_data_rx <= 8'h00;
            r_b_data_rx <= 8'h00;
            r_a_wait    <= 1'b1;
            r_b_wait    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            r_a_wait <= 1'b1;
            r_b_wait <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_a_req || w_b_req) begin
                        r_owner   <= w_pick;
                        r_address <= w_address;
                        r_data_tx <= w_data_tx;
                        r_read    <= w_read;
                        r_write   <= w_write;
                        r_state   <= GRANT;
                    end
                end

                GRANT: begin
                    if (!mem_bus.stall) begin
                        if (r_owner == PORT_B) begin
                            r_b_data_rx <= mem_bus.data_rx;
                            r_b_wait    <= 1'b0;
                        end else begin
                            r_a_data_rx <= mem_bus.data_rx;
                            r_a_wait    <= 1'b0;
                        end
                        r_last    <= r_owner;
                        r_address <= 16'h0000;
                        r_data_tx <= 8'h00;
                        r_read    <= 1'b0;
                        r_write   <= 1'b0;
                        r_state   <= RELEASE;
                    end
                end

                // Hold off until the controller finishes its deselect phase.
                RELEASE: begin
                    if (mem_bus.stall) begin
                        r_state <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_bus.address = r_address;
    assign mem_bus.data_tx = r_data_tx;
    assign mem_bus.read    = r_read;
    assign mem_bus.write   = r_write;

    assign a_bus.data_rx   = r_a_data_rx;
    assign a_bus.stall     = r_a_wait;
    assign b_bus.data_rx   = r_b_data_rx;
    assign b_bus.stall     = r_b_wait;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a round-robin and a fixed-priority instance, port
// drivers, a memory model and a scoreboard of expected transactions per instance.
module tb_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic [15:0] addr;
        logic        wr;
        logic [7:0]  data;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    int total = 0;
    int bad   = 0;
    int lat   = 6;
    int dummy = 1;

    logic [15:0] s_addr [2][2];
    logic [7:0]  s_dtx  [2][2];
    logic        s_rd   [2][2];
    logic        s_wr   [2][2];
    logic [7:0]  w_rx   [2][2];
    logic        w_wait [2][2];
    int          rem    [2][2];
    logic        prev_low [2][2];

    logic [15:0] mem_addr [2];
    logic [7:0]  mem_dtx  [2];
    logic        mem_rd   [2];
    logic        mem_wr   [2];
    logic [7:0]  m_rx     [2];
    logic        m_wait   [2];
    int          m_cnt    [2];
    int          m_dcnt   [2];
    logic        prev_strobe [2];

    for (genvar d = 0; d < 2; d++) begin : g_dut
        bus_arbiter_if a_if ();
        bus_arbiter_if b_if ();
        bus_arbiter_if m_if ();

        assign a_if.address = s_addr[d][0];
        assign a_if.data_tx = s_dtx[d][0];
        assign a_if.read    = s_rd[d][0];
        assign a_if.write   = s_wr[d][0];
        assign w_rx[d][0]   = a_if.data_rx;
        assign w_wait[d][0] = a_if.stall;

        assign b_if.address = s_addr[d][1];
        assign b_if.data_tx = s_dtx[d][1];
        assign b_if.read    = s_rd[d][1];
        assign b_if.write   = s_wr[d][1];
        assign w_rx[d][1]   = b_if.data_rx;
        assign w_wait[d][1] = b_if.stall;

        assign mem_addr[d]  = m_if.address;
        assign mem_dtx[d]   = m_if.data_tx;
        assign mem_rd[d]    = m_if.read;
        assign mem_wr[d]    = m_if.write;
        assign m_if.data_rx = m_rx[d];
        assign m_if.stall   = m_wait[d];

        bus_arbiter #(.FIXED_PRIORITY(d == 1)) dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .a_bus   (a_if),
            .b_bus   (b_if),
            .mem_bus (m_if)
        );
    end

    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'h78;
    endfunction

    function automatic int sb_size(input int d);
        return (d == 0) ? sb0.size() : sb1.size();
    endfunction

    function automatic exp_t sb_front(input int d);
        return (d == 0) ? sb0[0] : sb1[0];
    endfunction

    task automatic sb_push(input int d, input int p, input logic [15:0] a,
                           input logic w, input logic [7:0] dt);
        exp_t e;
        e.port = p;
        e.addr = a;
        e.wr   = w;
        e.data = dt;
        if (d == 0) sb0.push_back(e);
        else        sb1.push_back(e);
    endtask

    task automatic sb_pop(input int d, output exp_t e);
        if (d == 0) e = sb0.pop_front();
        else        e = sb1.pop_front();
    endtask

    // Checks every memory access start against the scoreboard head and every
    // completion pulse against the expected port and read data.
    task automatic monitor();
        exp_t e;
        logic strobe;
        for (int d = 0; d < 2; d++) begin
            strobe = mem_rd[d] | mem_wr[d];
            if (strobe && !prev_strobe[d]) begin
                total++;
                if (!m_wait[d]) begin
                    bad++;
                    $display("FAIL start_during_dummy dut%0d: strobe rose while mem_wait=0, required mem_wait=1", d);
                end else if (sb_size(d) == 0) begin
                    bad++;
                    $display("FAIL unexpected_access dut%0d: got addr=%h, required no access", d, mem_addr[d]);
                end else begin
                    e = sb_front(d);
                    if (mem_addr[d] !== e.addr || mem_wr[d] !== e.wr || mem_rd[d] !== !e.wr ||
                        (e.wr && mem_dtx[d] !== e.data)) begin
                        bad++;
                        $display("FAIL access dut%0d: got addr=%h rd=%b wr=%b dtx=%h, required addr=%h wr=%b dtx=%h",
                                 d, mem_addr[d], mem_rd[d], mem_wr[d], mem_dtx[d], e.addr, e.wr, e.data);
                    end
                end
            end
            if (!strobe) begin
                total++;
                if (mem_addr[d] !== 16'h0000 || mem_dtx[d] !== 8'h00) begin
                    bad++;
                    $display("FAIL bus_idle_zero dut%0d: got addr=%h dtx=%h, required 0000/00", d, mem_addr[d], mem_dtx[d]);
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (w_wait[d][p] === 1'b0) begin
                    total++;
                    if (prev_low[d][p]) begin
                        bad++;
                        $display("FAIL wait_pulse dut%0d port%0d: got wait low 2+ cycles, required 1", d, p);
                    end else if (sb_size(d) == 0) begin
                        bad++;
                        $display("FAIL spurious_done dut%0d port%0d: got wait=0, required 1", d, p);
                    end else begin
                        sb_pop(d, e);
                        if (e.port != p || (!e.wr && w_rx[d][p] !== mem_f(e.addr))) begin
                            bad++;
                            $display("FAIL done dut%0d: got port%0d rx=%h, required port%0d rx=%h",
                                     d, p, w_rx[d][p], e.port, mem_f(e.addr));
                        end
                    end
                end else if (w_wait[d][p] !== 1'b1) begin
                    total++;
                    bad++;
                    $display("FAIL wait_x dut%0d port%0d: got %b, required 1", d, p, w_wait[d][p]);
                end
                prev_low[d][p] = (w_wait[d][p] === 1'b0);
            end
            prev_strobe[d] = strobe;
        end
    endtask

    // Memory controller: stall for lat cycles, then mem_wait low for dummy cycles.
    task automatic mem_model();
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_wait[d] = 1'b1;
                m_cnt[d]  = 0;
                m_dcnt[d] = 0;
            end else if (m_wait[d]) begin
                if (mem_rd[d] | mem_wr[d]) begin
                    m_cnt[d]++;
                    if (m_cnt[d] >= lat) begin
                        m_wait[d] = 1'b0;
                        m_rx[d]   = mem_f(mem_addr[d]);
                        m_dcnt[d] = dummy;
                    end
                end else begin
                    m_cnt[d] = 0;
                end
            end else begin
                m_dcnt[d]--;
                if (m_dcnt[d] <= 0) begin
                    m_wait[d] = 1'b1;
                    m_cnt[d]  = 0;
                end
            end
        end
    endtask

    // Port drivers: hold a request until its wait pulse, then issue the next address.
    task automatic bfm();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                if ((s_rd[d][p] | s_wr[d][p]) && w_wait[d][p] === 1'b0) begin
                    rem[d][p]--;
                    if (rem[d][p] > 0) begin
                        s_addr[d][p] += 16'd1;
                    end else begin
                        s_rd[d][p] = 1'b0;
                        s_wr[d][p] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        mem_model();
        bfm();
    endtask

    task automatic clear_stim();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                s_addr[d][p]   = 16'h0000;
                s_dtx[d][p]    = 8'h00;
                s_rd[d][p]     = 1'b0;
                s_wr[d][p]     = 1'b0;
                rem[d][p]      = 0;
                prev_low[d][p] = 1'b0;
            end
            m_wait[d]      = 1'b1;
            m_rx[d]        = 8'h00;
            m_cnt[d]       = 0;
            m_dcnt[d]      = 0;
            prev_strobe[d] = 1'b0;
        end
        sb0.delete();
        sb1.delete();
        lat   = 6;
        dummy = 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_stim();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic start_req(input int d, input int p, input logic [15:0] a,
                             input logic w, input logic [7:0] dt, input int n);
        s_addr[d][p] = a;
        s_dtx[d][p]  = dt;
        s_wr[d][p]   = w;
        s_rd[d][p]   = !w;
        rem[d][p]    = n;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((sb_size(0) != 0 || sb_size(1) != 0) && n < budget) begin
            tick();
            n++;
        end
        if (sb_size(0) != 0 || sb_size(1) != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d/%0d pending after %0d cycles, required 0/0", sb_size(0), sb_size(1), budget);
            sb0.delete();
            sb1.delete();
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_stim();
        tick();
        for (int d = 0; d < 2; d++) begin
            total++;
            if (mem_rd[d] !== 1'b0 || mem_wr[d] !== 1'b0) begin
                bad++;
                $display("FAIL reset_strobes dut%0d: got rd=%b wr=%b, required 0/0", d, mem_rd[d], mem_wr[d]);
            end
            total++;
            if (w_wait[d][0] !== 1'b1 || w_wait[d][1] !== 1'b1) begin
                bad++;
                $display("FAIL reset_wait dut%0d: got a=%b b=%b, required 1/1", d, w_wait[d][0], w_wait[d][1]);
            end
            total++;
            if (w_rx[d][0] !== 8'h00 || w_rx[d][1] !== 8'h00) begin
                bad++;
                $display("FAIL reset_rx dut%0d: got a=%h b=%h, required 00/00", d, w_rx[d][0], w_rx[d][1]);
            end
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        sb_push(0, 0, 16'h0123, 1'b0, 8'h00);
        start_req(0, 0, 16'h0123, 1'b0, 8'h00, 1);
        tick();
        total++;
        if (mem_rd[0] !== 1'b1 || mem_addr[0] !== 16'h0123) begin
            bad++;
            $display("FAIL read_latency: got rd=%b addr=%h one cycle after request, required 1/0123", mem_rd[0], mem_addr[0]);
        end
        wait_done(40);
        total++;
        if (w_rx[0][0] !== 8'h5A || w_rx[0][1] !== 8'h00) begin
            bad++;
            $display("FAIL read_data: got a_rx=%h b_rx=%h, required 5a/00", w_rx[0][0], w_rx[0][1]);
        end
    endtask

    task automatic test_read_write_both();
        do_reset();
        sb_push(0, 0, 16'h0500, 1'b1, 8'h11);
        start_req(0, 0, 16'h0500, 1'b1, 8'h11, 1);
        s_rd[0][0] = 1'b1;
        wait_done(40);
    endtask

    task automatic test_tie();
        for (int d = 0; d < 2; d++) begin
            sb_push(d, 0, 16'h1000, 1'b0, 8'h00);
            sb_push(d, 1, 16'h2000, 1'b0, 8'h00);
            start_req(d, 0, 16'h1000, 1'b0, 8'h00, 1);
            start_req(d, 1, 16'h2000, 1'b0, 8'h00, 1);
        end
        wait_done(80);
        total++;
        if (w_rx[0][0] !== mem_f(16'h1000) || w_rx[0][1] !== mem_f(16'h2000)) begin
            bad++;
            $display("FAIL tie_data: got a_rx=%h b_rx=%h, required %h/%h",
                     w_rx[0][0], w_rx[0][1], mem_f(16'h1000), mem_f(16'h2000));
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            sb_push(0, 0, 16'h0100 + 16'(i), 1'b0, 8'h00);
            sb_push(0, 1, 16'h0200 + 16'(i), 1'b0, 8'h00);
        end
        for (int i = 0; i < 3; i++) sb_push(1, 0, 16'h0100 + 16'(i), 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) sb_push(1, 1, 16'h0200 + 16'(i), 1'b0, 8'h00);
        for (int d = 0; d < 2; d++) begin
            start_req(d, 0, 16'h0100, 1'b0, 8'h00, 3);
            start_req(d, 1, 16'h0200, 1'b0, 8'h00, 3);
        end
        wait_done(300);
    endtask

    task automatic test_write_hold();
        do_reset();
        sb_push(0, 1, 16'h8010, 1'b1, 8'hC3);
        start_req(0, 1, 16'h8010, 1'b1, 8'hC3, 1);
        tick();
        s_wr[0][1]   = 1'b0;
        s_addr[0][1] = 16'h0000;
        s_dtx[0][1]  = 8'h00;
        rem[0][1]    = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (mem_addr[0] !== 16'h8010 || mem_dtx[0] !== 8'hC3 || mem_wr[0] !== 1'b1 || mem_rd[0] !== 1'b0) begin
                bad++;
                $display("FAIL write_hold cycle%0d: got addr=%h dtx=%h wr=%b rd=%b, required 8010/c3/1/0",
                         i, mem_addr[0], mem_dtx[0], mem_wr[0], mem_rd[0]);
            end
        end
        wait_done(40);
    endtask

    task automatic test_dummy_clock();
        int n = 0;
        do_reset();
        dummy = 3;
        sb_push(0, 0, 16'h0040, 1'b0, 8'h00);
        sb_push(0, 0, 16'h0041, 1'b0, 8'h00);
        start_req(0, 0, 16'h0040, 1'b0, 8'h00, 2);
        tick();
        while (w_wait[0][0] !== 1'b0 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (w_wait[0][0] !== 1'b0) begin
            bad++;
            $display("FAIL dummy_first_done: got wait=%b after 40 cycles, required 0", w_wait[0][0]);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (mem_rd[0] !== 1'b0 || mem_wr[0] !== 1'b0 || w_wait[0][0] !== 1'b1) begin
                bad++;
                $display("FAIL dummy_hold cycle%0d: got rd=%b wr=%b wait=%b, required 0/0/1",
                         i, mem_rd[0], mem_wr[0], w_wait[0][0]);
            end
        end
        wait_done(60);
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        sb_push(0, 0, 16'h0300, 1'b0, 8'h00);
        start_req(0, 0, 16'h0300, 1'b0, 8'h00, 1);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (mem_rd[0] !== 1'b0 || mem_addr[0] !== 16'h0000) begin
            bad++;
            $display("FAIL async_reset_strobe: got rd=%b addr=%h, required 0/0000", mem_rd[0], mem_addr[0]);
        end
        total++;
        if (w_wait[0][0] !== 1'b1 || w_wait[0][1] !== 1'b1) begin
            bad++;
            $display("FAIL async_reset_wait: got a=%b b=%b, required 1/1", w_wait[0][0], w_wait[0][1]);
        end
        clear_stim();
        tick();
        tick();
        rst_n = 1'b1;
        test_tie();
    endtask

    initial begin
        clear_stim();
        test_reset();
        test_single_read();
        test_read_write_both();
        do_reset();
        test_tie();
        test_back_to_back();
        test_write_hold();
        test_dummy_clock();
        test_reset_mid_grant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
